// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_if
//  Purpose  : Bundles the ID/EXE/MEM status inputs and the freeze/flush
//             control outputs of the hazard control unit.
//  Ports    : src1/src2, has_src1/two_src, exe_dest/mem_dest, exe_wb_en,
//             mem_wb_en, exe_mem_read, forward_en, branch_taken, mem_req
//             (pipeline -> controller); pc_freeze, if_id_freeze,
//             if_id_flush, id_ex_flush, mem_stall, mem_done, stall_cnt,
//             flush_cnt (controller -> pipeline).
//  Modports : master = hazard controller, slave = pipeline side.
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             has_src1;
  logic             two_src;
  logic [3:0]       exe_dest;
  logic [3:0]       mem_dest;
  logic             exe_wb_en;
  logic             mem_wb_en;
  logic             exe_mem_read;
  logic             forward_en;
  logic             branch_taken;
  logic             mem_req;

  logic             pc_freeze;
  logic             if_id_freeze;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_stall;
  logic             mem_done;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  src1, src2, has_src1, two_src, exe_dest, mem_dest,
           exe_wb_en, mem_wb_en, exe_mem_read, forward_en,
           branch_taken, mem_req,
    output pc_freeze, if_id_freeze, if_id_flush, id_ex_flush,
           mem_stall, mem_done, stall_cnt, flush_cnt
  );

  modport slave (
    output src1, src2, has_src1, two_src, exe_dest, mem_dest,
           exe_wb_en, mem_wb_en, exe_mem_read, forward_en,
           branch_taken, mem_req,
    input  pc_freeze, if_id_freeze, if_id_flush, id_ex_flush,
           mem_stall, mem_done, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline freeze/flush control. Resolves multi-cycle data-memory
//             stalls (wait-state FSM), taken-branch flushes and register
//             dependency hazards, and counts stall/flush cycles with
//             saturating counters.
//  Ports    : clk  - pipeline clock, rising edge
//             rst  - synchronous active-high reset; forces all outputs to 0
//             bus  - hazard_ctrl_if.master (status in, controls out)
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MEM_WAIT = 4,   // stall cycles per memory access, 2..15
  parameter int CNT_W    = 16   // performance counter width
) (
  input  wire logic     clk,
  input  wire logic     rst,
  hazard_ctrl_if.master bus
);

  // Reload so that IDLE (1 cycle) + WAIT (MEM_WAIT-1 cycles) = MEM_WAIT stalls.
  localparam logic [3:0] c_WAIT_LOAD = 4'(MEM_WAIT - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_wcnt;
  logic [3:0]       w_wcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_mem_stall;
  logic w_mem_done;
  logic w_src1_hit;
  logic w_src2_hit;
  logic w_hazard;
  logic w_pc_freeze;
  logic w_if_id_freeze;
  logic w_if_id_flush;
  logic w_id_ex_flush;

  // --------------------------------------------------------------------------
  // Memory wait-state FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_req) begin
          w_state_nxt = S_WAIT;
          w_wcnt_nxt  = c_WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (r_wcnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_wcnt_nxt = r_wcnt - 4'd1;
        end
      end
      // The finishing instruction is still in MEM, so its mem_req must not
      // start another access.
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_mem_stall = ((r_state == S_IDLE) && bus.mem_req) || (r_state == S_WAIT);
  assign w_mem_done  = (r_state == S_DONE);

  // --------------------------------------------------------------------------
  // Register dependency detection. With forwarding only a load in EXE can
  // not be bypassed in time; without it any pending write is a hazard.
  // Register 0 is an ordinary register here.
  // --------------------------------------------------------------------------
  always_comb begin
    w_src1_hit = 1'b0;
    w_src2_hit = 1'b0;
    if (bus.forward_en) begin
      w_src1_hit = bus.exe_mem_read && bus.exe_wb_en && (bus.src1 == bus.exe_dest);
      w_src2_hit = bus.exe_mem_read && bus.exe_wb_en && (bus.src2 == bus.exe_dest);
    end else begin
      w_src1_hit = (bus.exe_wb_en && (bus.src1 == bus.exe_dest)) ||
                   (bus.mem_wb_en && (bus.src1 == bus.mem_dest));
      w_src2_hit = (bus.exe_wb_en && (bus.src2 == bus.exe_dest)) ||
                   (bus.mem_wb_en && (bus.src2 == bus.mem_dest));
    end
  end

  assign w_hazard = (bus.has_src1 && w_src1_hit) || (bus.two_src && w_src2_hit);

  // --------------------------------------------------------------------------
  // Control priority: memory stall > taken branch > data hazard. A branch
  // seen during a memory stall is not lost: EXE is frozen, so branch_taken
  // is still asserted once the stall ends.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_freeze    = 1'b0;
    w_if_id_freeze = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    if (w_mem_stall) begin
      w_pc_freeze    = 1'b1;
      w_if_id_freeze = 1'b1;
    end else if (bus.branch_taken) begin
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
    end else if (w_hazard) begin
      w_pc_freeze    = 1'b1;
      w_if_id_freeze = 1'b1;
      w_id_ex_flush  = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pc_freeze && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_if_id_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  // All outputs are held low while reset is asserted.
  assign bus.pc_freeze    = !rst && w_pc_freeze;
  assign bus.if_id_freeze = !rst && w_if_id_freeze;
  assign bus.if_id_flush  = !rst && w_if_id_flush;
  assign bus.id_ex_flush  = !rst && w_id_ex_flush;
  assign bus.mem_stall    = !rst && w_mem_stall;
  assign bus.mem_done     = !rst && w_mem_done;
  assign bus.stall_cnt    = rst ? '0 : r_stall_cnt;
  assign bus.flush_cnt    = rst ? '0 : r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl (MEM_WAIT=4, CNT_W=4).
//             Each cycle's expected controls are pushed to a scoreboard
//             queue together with the expected counter values, then popped
//             and compared once the combinational outputs have settled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int MEM_WAIT = 4;
  localparam int CNT_W    = 4;

  // Expected control codes {pc_freeze, if_id_freeze, if_id_flush,
  //                         id_ex_flush, mem_stall, mem_done}
  localparam logic [5:0] c_N  = 6'b000000;
  localparam logic [5:0] c_S  = 6'b110010;  // memory stall
  localparam logic [5:0] c_D  = 6'b000001;  // access done
  localparam logic [5:0] c_H  = 6'b110100;  // data hazard
  localparam logic [5:0] c_F  = 6'b001100;  // branch flush
  localparam logic [5:0] c_FD = 6'b001101;  // branch flush in DONE cycle

  logic clk;
  logic rst;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(
    .MEM_WAIT (MEM_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [5+2*CNT_W:0] sb[$];
  logic [CNT_W-1:0]   t_sc = '0;
  logic [CNT_W-1:0]   t_fc = '0;

  // Stimulus vector: {rst, mem_req, branch_taken, forward_en, exe_mem_read,
  // exe_wb_en, mem_wb_en, has_src1, two_src, src1, src2, exe_dest, mem_dest}
  function automatic logic [24:0] mk(
    input logic r, req, br, fe, emr, ewb, mwb, hs1, ts,
    input logic [3:0] s1, s2, ed, md
  );
    return {r, req, br, fe, emr, ewb, mwb, hs1, ts, s1, s2, ed, md};
  endfunction

  task automatic apply(input logic [24:0] s);
    {rst, bus.mem_req, bus.branch_taken, bus.forward_en, bus.exe_mem_read,
     bus.exe_wb_en, bus.mem_wb_en, bus.has_src1, bus.two_src,
     bus.src1, bus.src2, bus.exe_dest, bus.mem_dest} = s;
  endtask

  // Push this cycle's expectation; the counters shown are the values before
  // the coming edge, and the tallies advance as that edge would.
  task automatic push_exp(input logic [5:0] ctl, input logic r);
    if (r) begin
      sb.push_back({6'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}});
      t_sc = '0;
      t_fc = '0;
    end else begin
      sb.push_back({ctl, t_sc, t_fc});
      if (ctl[5] && t_sc != {CNT_W{1'b1}}) t_sc = t_sc + 1'b1;
      if (ctl[3] && t_fc != {CNT_W{1'b1}}) t_fc = t_fc + 1'b1;
    end
  endtask

  function automatic logic [5+2*CNT_W:0] observed();
    return {bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush, bus.id_ex_flush,
            bus.mem_stall, bus.mem_done, bus.stall_cnt, bus.flush_cnt};
  endfunction

  localparam logic [24:0] c_IDLE = 25'd0;

  task automatic test_reset();
    logic [24:0] st[3];
    logic [5:0]  ex[3];
    logic [5+2*CNT_W:0] got, want;
    st = '{mk(1,1,1,0,0,1,1,1,1,4'd3,4'd3,4'd3,4'd3),
           mk(1,1,1,0,0,1,1,1,1,4'd3,4'd3,4'd3,4'd3), c_IDLE};
    ex = '{c_N, c_N, c_N};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); apply(st[i]); push_exp(ex[i], st[i][24]);
      #2; got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset cyc %0d got %b expected %b", i, got, want);
      end
    end
  endtask

  // Two accesses back to back: the second request is honoured right after
  // the DONE cycle, then the request is dropped while still waiting.
  task automatic test_back_to_back();
    logic [24:0] st[11];
    logic [5:0]  ex[11];
    logic [24:0] rq;
    logic [5+2*CNT_W:0] got, want;
    rq = mk(0,1,0,0,0,0,0,0,0,4'd0,4'd0,4'd0,4'd0);
    st = '{rq, rq, rq, rq, rq, rq, c_IDLE, c_IDLE, c_IDLE, c_IDLE, c_IDLE};
    ex = '{c_S, c_S, c_S, c_S, c_D, c_S, c_S, c_S, c_S, c_D, c_N};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); apply(st[i]); push_exp(ex[i], st[i][24]);
      #2; got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [24:0] st[8];
    logic [5:0]  ex[8];
    logic [24:0] rq;
    logic [5+2*CNT_W:0] got, want;
    rq = mk(0,1,0,0,0,0,0,0,0,4'd0,4'd0,4'd0,4'd0);
    st = '{rq, mk(1,1,0,0,0,0,0,0,0,4'd0,4'd0,4'd0,4'd0), c_IDLE, rq,
           c_IDLE, c_IDLE, c_IDLE, c_IDLE};
    ex = '{c_S, c_N, c_N, c_S, c_S, c_S, c_S, c_D};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); apply(st[i]); push_exp(ex[i], st[i][24]);
      #2; got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_wait cyc %0d got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_hazard();
    logic [24:0] st[7];
    logic [5:0]  ex[7];
    logic [5+2*CNT_W:0] got, want;
    st = '{mk(0,0,0,0,0,0,1,1,0,4'd3,4'd0,4'd0,4'd3),   // MEM match, no fwd
           mk(0,0,0,1,0,0,1,1,0,4'd3,4'd0,4'd0,4'd3),   // forwarded
           mk(0,0,0,0,0,1,0,0,1,4'd0,4'd7,4'd7,4'd0),   // src2 vs EXE
           mk(0,0,0,0,0,1,0,0,0,4'd0,4'd7,4'd7,4'd0),   // src2 unused
           mk(0,0,0,0,0,1,0,1,0,4'd0,4'd0,4'd0,4'd0),   // r0 is real
           mk(0,0,0,0,0,0,0,1,0,4'd0,4'd0,4'd0,4'd0),   // no writeback
           mk(0,0,0,0,0,1,1,1,1,4'd2,4'd4,4'd6,4'd8)};  // no match
    ex = '{c_H, c_N, c_H, c_N, c_H, c_N, c_N};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); apply(st[i]); push_exp(ex[i], st[i][24]);
      #2; got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hazard cyc %0d got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    logic [24:0] st[5];
    logic [5:0]  ex[5];
    logic [5+2*CNT_W:0] got, want;
    st = '{mk(0,0,0,1,1,1,0,0,1,4'd0,4'd5,4'd5,4'd0),
           mk(0,0,0,1,0,1,0,0,1,4'd0,4'd5,4'd5,4'd0),
           mk(0,0,0,1,1,0,0,0,1,4'd0,4'd5,4'd5,4'd0),
           mk(0,0,0,1,1,1,0,1,0,4'd9,4'd0,4'd9,4'd0),
           mk(0,0,0,1,1,1,0,0,0,4'd9,4'd0,4'd9,4'd0)};
    ex = '{c_H, c_N, c_N, c_H, c_N};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); apply(st[i]); push_exp(ex[i], st[i][24]);
      #2; got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL load_use cyc %0d got %b expected %b", i, got, want);
      end
    end
  endtask

  // Branch beats hazard; memory stall beats both and the branch flush
  // appears in the DONE cycle.
  task automatic test_branch();
    logic [24:0] st[8];
    logic [5:0]  ex[8];
    logic [24:0] all3, br_hz;
    logic [5+2*CNT_W:0] got, want;
    all3  = mk(0,1,1,0,0,1,1,1,1,4'd3,4'd3,4'd3,4'd3);
    br_hz = mk(0,0,1,0,0,1,1,1,1,4'd3,4'd3,4'd3,4'd3);
    st = '{mk(0,0,1,0,0,0,1,1,0,4'd3,4'd0,4'd0,4'd3), c_IDLE,
           all3, br_hz, br_hz, br_hz, br_hz, c_IDLE};
    ex = '{c_F, c_N, c_S, c_S, c_S, c_S, c_FD, c_N};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); apply(st[i]); push_exp(ex[i], st[i][24]);
      #2; got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL branch cyc %0d got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_saturation();
    logic [24:0] hz;
    logic [24:0] s;
    logic [5:0]  e;
    logic [5+2*CNT_W:0] got, want;
    hz = mk(0,0,0,0,0,0,1,1,0,4'd3,4'd0,4'd0,4'd3);
    for (int i = 0; i < 22; i++) begin
      if (i == 0) begin
        s = mk(1,0,0,0,0,0,0,0,0,4'd0,4'd0,4'd0,4'd0); e = c_N;
      end else if (i == 21) begin
        s = c_IDLE; e = c_N;
      end else begin
        s = hz; e = c_H;
      end
      @(negedge clk); apply(s); push_exp(e, s[24]);
      #2; got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL saturation cyc %0d got %b expected %b", i, got, want);
      end
    end
  endtask

  initial begin
    apply(mk(1,0,0,0,0,0,0,0,0,4'd0,4'd0,4'd0,4'd0));
    test_reset();
    test_back_to_back();
    test_reset_mid_wait();
    test_hazard();
    test_load_use();
    test_branch();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit that generates the freeze and flush controls consumed by the IF/ID pipeline register, the PC register and the ID/EX register. It resolves three event classes: multi-cycle data-memory stalls (sequential wait-state FSM), taken-branch flushes, and register-dependency hazards. It sits beside the ID stage, takes register indices and status from ID, EXE and MEM, and also keeps saturating stall/flush performance counters.

## Interface
- MEM_WAIT, 4: stall cycles per data-memory access; legal range 2..15.
- CNT_W, 16: width of the performance counters.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- src1, src2  in  4 each  ID-stage source register indices.
- has_src1, two_src  in  1 each  ID instruction reads src1 / also reads src2.
- exe_dest, mem_dest  in  4 each  destination registers of EXE and MEM instructions.
- exe_wb_en, mem_wb_en  in  1 each  EXE / MEM instruction writes back.
- exe_mem_read  in  1  EXE instruction is a load.
- forward_en  in  1  forwarding unit active.
- branch_taken  in  1  EXE stage resolved a taken branch.
- mem_req  in  1  MEM instruction is a load or store.
- pc_freeze  out  1  hold PC.
- if_id_freeze  out  1  hold IF/ID register.
- if_id_flush  out  1  zero IF/ID register.
- id_ex_flush  out  1  insert bubble into ID/EX.
- mem_stall  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- mem_done  out  1  one-cycle pulse: memory access completes this cycle.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

## Operation
- FSM states: IDLE, WAIT, DONE. Down-counter wcnt, 4 bits.
- IDLE: mem_req=1 -> WAIT, wcnt <= MEM_WAIT-2. Otherwise stay.
- WAIT: wcnt==0 -> DONE; else wcnt <= wcnt-1.
- DONE: always -> IDLE. mem_req is ignored here because the same instruction is still in MEM; this prevents a re-trigger.
- mem_stall = (IDLE & mem_req) | WAIT. An access therefore stalls exactly MEM_WAIT cycles, followed by one DONE cycle.
- mem_done = (state==DONE).
- hazard, forward_en=0: (has_src1 & src1 matches a dest) | (two_src & src2 matches a dest). A dest matches when exe_wb_en & exe_dest, or mem_wb_en & mem_dest, is equal to the source index.
- hazard, forward_en=1: exe_mem_read & exe_wb_en & ((has_src1 & src1==exe_dest) | (two_src & src2==exe_dest)). MEM-stage matches are ignored.
- Output priority, highest first:
  - mem_stall=1: pc_freeze=1, if_id_freeze=1, if_id_flush=0, id_ex_flush=0. A branch is deferred, not lost, because EXE is frozen and branch_taken persists.
  - branch_taken=1: if_id_flush=1, id_ex_flush=1, pc_freeze=0, if_id_freeze=0. The hazard is ignored.
  - hazard=1: pc_freeze=1, if_id_freeze=1, id_ex_flush=1, if_id_flush=0.
  - otherwise: all control outputs are 0.
- stall_cnt increments on every cycle with pc_freeze=1. flush_cnt increments on every cycle with if_id_flush=1. Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- All control outputs are combinational from inputs and state. Zero-cycle latency to the registers they control.
- rst=1 at an edge: state<=IDLE, wcnt<=0, stall_cnt<=0, flush_cnt<=0. This also applies mid-WAIT.
- While rst=1, all outputs are forced to 0 (mem_stall, mem_done, both counters included).
- First cycle after reset is IDLE. mem_req=1 there stalls immediately.
- Back-to-back accesses: the next mem_req is honoured in the first IDLE cycle after DONE. There is no idle gap beyond the DONE cycle.
- Simultaneous mem_stall, branch_taken and hazard: only the mem_stall response is driven.
- src==0 is treated as a normal register. There is no hard-wired zero exemption.

## Test plan
- Reset during WAIT (MEM_WAIT=4, rst asserted 2nd stall cycle) -> next cycle state IDLE, mem_stall=0, stall_cnt=0.
- Load access, MEM_WAIT=4, mem_req held high 6 cycles -> mem_stall=1 for cycles 1-4, mem_done=1 in cycle 5, mem_stall=0 in cycle 5. A mem_req still high in cycle 6 (new instruction) -> stall restarts in cycle 6.
- forward_en=0, src1=3, has_src1=1, mem_dest=3, mem_wb_en=1 -> pc_freeze=1, if_id_freeze=1, id_ex_flush=1, stall_cnt +1. Same with forward_en=1 -> no stall.
- forward_en=1, exe_mem_read=1, exe_wb_en=1, exe_dest=5, two_src=1, src2=5 -> load-use stall for one cycle. Drop exe_mem_read -> stall clears the same cycle.
- branch_taken=1 with a concurrent hazard -> if_id_flush=1, id_ex_flush=1, pc_freeze=0, flush_cnt +1. branch_taken=1 during mem_stall -> no flush until stall ends, then flush for one cycle.
- CNT_W=4, hazard held 20 cycles -> stall_cnt reaches 15 and holds at 15.
